// File: rtl/hangman_pkg.sv
// Shared types, ASCII constants and the row-centring helper for the hangman host display.
package hangman_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StWin  = 2'd2,
        StLose = 2'd3
    } game_state_t;

    localparam logic [7:0]  BLANK      = 8'h20;
    localparam logic [7:0]  UNDERSCORE = 8'h5F;
    localparam logic [23:0] WIN_STR    = 24'h57_69_6E;
    localparam logic [31:0] LOSE_STR   = 32'h4C_6F_73_65;

    // Widest row the helper can format; narrower rows use the low bytes.
    localparam int unsigned MAX_ROW_CHARS = 32;
    typedef logic [8*MAX_ROW_CHARS-1:0] row_t;

    // field holds n chars in its low bytes (char0 most significant); the result holds
    // row_chars chars in its low bytes with the field starting at (row_chars-n)/2.
    function automatic row_t centre_field(input row_t field, input int unsigned n,
                                          input int unsigned row_chars);
        row_t        row;
        int unsigned left;
        row  = {MAX_ROW_CHARS{BLANK}};
        left = (row_chars - n) / 2;
        for (int unsigned i = 0; i < MAX_ROW_CHARS; i++) begin
            if (i < n) begin
                row[8*(row_chars-1-left-i) +: 8] = field[8*(n-1-i) +: 8];
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/hangman_guess_history.sv
// Wrong-guess history: newest letter enters char0, oldest drops off the end.
// Also flags whether the presented letter already sits in the history.
module hangman_guess_history
    import hangman_pkg::*;
#(
    parameter int unsigned DEPTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic [7:0]         letter,
    output logic [8*DEPTH-1:0] hist,
    output logic               match
);

    logic [8*DEPTH-1:0] hist_q, hist_d;
    logic [8*DEPTH+7:0] shifted;

    assign shifted = {letter, hist_q};

    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = {DEPTH{UNDERSCORE}};
        end else if (shift) begin
            hist_d = shifted[8*DEPTH+7:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= {DEPTH{UNDERSCORE}};
        end else begin
            hist_q <= hist_d;
        end
    end

    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (hist_q[8*i +: 8] == letter) begin
                match = 1'b1;
            end
        end
    end

    assign hist = hist_q;

endmodule

// File: rtl/hangman_host_display_gen.sv
// Host-side hangman round tracker that renders two centred, space-padded LCD rows.
module hangman_host_display_gen
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN     = 5,
    parameter int unsigned MAX_MISTAKES = 6,
    parameter int unsigned ROW_CHARS    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [8*WORD_LEN-1:0]        word,
    input  logic                         guess_valid,
    input  logic [7:0]                   letter,
    input  logic [WORD_LEN-1:0]          index_correct,
    input  logic                         mistake,
    output logic [8*ROW_CHARS-1:0]       top,
    output logic [8*ROW_CHARS-1:0]       bottom,
    output logic [1:0]                   game_state,
    output logic [3:0]                   mistake_cnt,
    output logic [$clog2(WORD_LEN+1)-1:0] correct_cnt,
    output logic                         dup_guess
);

    localparam int unsigned CW = $clog2(WORD_LEN + 1);

    if (WORD_LEN < 1 || WORD_LEN > ROW_CHARS) begin : g_bad_word_len
        $fatal(1, "WORD_LEN must be in 1..ROW_CHARS");
    end
    if (MAX_MISTAKES < 1 || MAX_MISTAKES > 9 || MAX_MISTAKES > ROW_CHARS) begin : g_bad_mistakes
        $fatal(1, "MAX_MISTAKES must be in 1..9 and not exceed ROW_CHARS");
    end
    if (ROW_CHARS > MAX_ROW_CHARS) begin : g_bad_row
        $fatal(1, "ROW_CHARS exceeds MAX_ROW_CHARS");
    end

    game_state_t               state_q, state_d;
    logic [8*WORD_LEN-1:0]     word_q, word_d;
    logic [8*WORD_LEN-1:0]     slots_q, slots_d;
    logic [3:0]                mcnt_q, mcnt_d;
    logic [CW-1:0]             ccnt_q, ccnt_d;
    logic                      dup_q, dup_d;

    logic                      hist_clear, hist_shift, hist_match;
    logic [8*MAX_MISTAKES-1:0] hist;
    logic                      slot_match;
    logic [WORD_LEN-1:0]       new_mask;
    logic [CW-1:0]             new_cnt;

    hangman_guess_history #(
        .DEPTH (MAX_MISTAKES)
    ) u_history (
        .clk    (clk),
        .rst    (rst),
        .clear  (hist_clear),
        .shift  (hist_shift),
        .letter (letter),
        .hist   (hist),
        .match  (hist_match)
    );

    // Slot scan: revealed-letter match for duplicates, and which hits are new reveals.
    always_comb begin
        slot_match = 1'b0;
        new_mask   = '0;
        new_cnt    = '0;
        for (int unsigned i = 0; i < WORD_LEN; i++) begin
            if (slots_q[8*i +: 8] != UNDERSCORE && slots_q[8*i +: 8] == letter) begin
                slot_match = 1'b1;
            end
            if (index_correct[i] && slots_q[8*i +: 8] == UNDERSCORE) begin
                new_mask[i] = 1'b1;
                new_cnt     = new_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        slots_d    = slots_q;
        mcnt_d     = mcnt_q;
        ccnt_d     = ccnt_q;
        dup_d      = 1'b0;
        hist_clear = 1'b0;
        hist_shift = 1'b0;
        if (start) begin
            word_d     = word;
            slots_d    = {WORD_LEN{UNDERSCORE}};
            mcnt_d     = '0;
            ccnt_d     = '0;
            hist_clear = 1'b1;
            state_d    = StPlay;
        end else if (guess_valid && state_q == StPlay) begin
            if (slot_match || hist_match) begin
                dup_d = 1'b1;
            end else if (mistake) begin
                hist_shift = 1'b1;
                mcnt_d     = mcnt_q + 4'd1;
                if (mcnt_d == 4'(MAX_MISTAKES)) begin
                    state_d = StLose;
                end
            end else if (index_correct != '0) begin
                for (int unsigned i = 0; i < WORD_LEN; i++) begin
                    if (new_mask[i]) begin
                        slots_d[8*i +: 8] = letter;
                    end
                end
                ccnt_d = ccnt_q + new_cnt;
                if (ccnt_d == CW'(WORD_LEN)) begin
                    state_d = StWin;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            slots_q <= {WORD_LEN{UNDERSCORE}};
            mcnt_q  <= '0;
            ccnt_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            slots_q <= slots_d;
            mcnt_q  <= mcnt_d;
            ccnt_q  <= ccnt_d;
            dup_q   <= dup_d;
        end
    end

    row_t top_row, bottom_row;

    always_comb begin
        top_row    = {MAX_ROW_CHARS{BLANK}};
        bottom_row = {MAX_ROW_CHARS{BLANK}};
        case (state_q)
            StPlay: begin
                top_row    = centre_field(row_t'(slots_q), WORD_LEN, ROW_CHARS);
                bottom_row = centre_field(row_t'(hist), MAX_MISTAKES, ROW_CHARS);
            end
            StWin: begin
                top_row    = centre_field(row_t'(WIN_STR), 3, ROW_CHARS);
                bottom_row = centre_field(row_t'(word_q), WORD_LEN, ROW_CHARS);
            end
            StLose: begin
                top_row    = centre_field(row_t'(LOSE_STR), 4, ROW_CHARS);
                bottom_row = centre_field(row_t'(word_q), WORD_LEN, ROW_CHARS);
            end
            default: ;
        endcase
    end

    assign top         = top_row[8*ROW_CHARS-1:0];
    assign bottom      = bottom_row[8*ROW_CHARS-1:0];
    assign game_state  = state_q;
    assign mistake_cnt = mcnt_q;
    assign correct_cnt = ccnt_q;
    assign dup_guess   = dup_q;

endmodule

// File: tb/tb_hangman_host_display_gen.sv
// Directed bench for the hangman host display: default 5-letter instance plus a 7-letter one.
module tb_hangman_host_display_gen;

    logic         clk = 1'b0;
    logic         rst, start, guess_valid, mistake;
    logic [7:0]   letter;
    logic [39:0]  word5;
    logic [55:0]  word7;
    logic [4:0]   ic5;
    logic [6:0]   ic7;

    logic [127:0] top5, bottom5, top7, bottom7;
    logic [1:0]   st5, st7;
    logic [3:0]   mc5, mc7;
    logic [2:0]   cc5;
    logic [3:0]   cc7;
    logic         dup5, dup7;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hangman_host_display_gen dut5 (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .word          (word5),
        .guess_valid   (guess_valid),
        .letter        (letter),
        .index_correct (ic5),
        .mistake       (mistake),
        .top           (top5),
        .bottom        (bottom5),
        .game_state    (st5),
        .mistake_cnt   (mc5),
        .correct_cnt   (cc5),
        .dup_guess     (dup5)
    );

    hangman_host_display_gen #(
        .WORD_LEN     (7),
        .MAX_MISTAKES (6),
        .ROW_CHARS    (16)
    ) dut7 (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .word          (word7),
        .guess_valid   (guess_valid),
        .letter        (letter),
        .index_correct (ic7),
        .mistake       (mistake),
        .top           (top7),
        .bottom        (bottom7),
        .game_state    (st7),
        .mistake_cnt   (mc7),
        .correct_cnt   (cc7),
        .dup_guess     (dup7)
    );

    typedef struct packed {
        logic [127:0] top;
        logic [127:0] bot;
        logic [1:0]   st;
        logic [3:0]   mc;
        logic [3:0]   cc;
        logic         dup;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];

    function automatic logic [127:0] row16(input string s, input int off);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < s.len(); i++) r[8*(15-off-i) +: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        assert (got === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Push expectation, clock once, drop pulses, then pop and compare.
    task automatic cycle(input string tag, input logic [127:0] et, input logic [127:0] eb,
                         input logic [1:0] est, input int emc, input int ecc,
                         input logic edup, input bit seven);
        exp_t  e;
        string t;
        e.top = et; e.bot = eb; e.st = est;
        e.mc = 4'(emc); e.cc = 4'(ecc); e.dup = edup;
        sbq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; guess_valid = 1'b0;
        mistake = 1'b0; ic5 = '0; ic7 = '0;
        e = sbq.pop_front();
        t = tagq.pop_front();
        if (!seven) begin
            chk({t, ".top"}, top5, e.top);
            chk({t, ".bottom"}, bottom5, e.bot);
            chk({t, ".state"}, 128'(st5), 128'(e.st));
            chk({t, ".mistake_cnt"}, 128'(mc5), 128'(e.mc));
            chk({t, ".correct_cnt"}, 128'(cc5), 128'(e.cc));
            chk({t, ".dup"}, 128'(dup5), 128'(e.dup));
        end else begin
            chk({t, ".top"}, top7, e.top);
            chk({t, ".bottom"}, bottom7, e.bot);
            chk({t, ".state"}, 128'(st7), 128'(e.st));
            chk({t, ".mistake_cnt"}, 128'(mc7), 128'(e.mc));
            chk({t, ".correct_cnt"}, 128'(cc7), 128'(e.cc));
            chk({t, ".dup"}, 128'(dup7), 128'(e.dup));
        end
    endtask

    task automatic guess(input logic [7:0] l, input logic [4:0] i5, input logic [6:0] i7,
                         input logic m);
        guess_valid = 1'b1; letter = l; ic5 = i5; ic7 = i7; mistake = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] bl, u5, h6, hello;
        bl    = row16("", 0);
        u5    = row16("_____", 5);
        h6    = row16("______", 5);
        hello = row16("HELLO", 5);

        rst = 1'b1; start = 1'b0; guess_valid = 1'b0; mistake = 1'b0;
        letter = 8'h00; ic5 = '0; ic7 = '0;
        word5 = "HELLO"; word7 = "GALLOWS";

        cycle("reset", bl, bl, 2'd0, 0, 0, 1'b0, 0);
        start = 1'b1;
        cycle("start", u5, h6, 2'd1, 0, 0, 1'b0, 0);
        guess("L", 5'b00110, '0, 1'b0);
        cycle("hit_L", row16("__LL_", 5), h6, 2'd1, 0, 2, 1'b0, 0);
        guess("L", 5'b00110, '0, 1'b0);
        cycle("dup_L", row16("__LL_", 5), h6, 2'd1, 0, 2, 1'b1, 0);
        cycle("dup_end", row16("__LL_", 5), h6, 2'd1, 0, 2, 1'b0, 0);
        guess("Z", '0, '0, 1'b1);
        cycle("miss_Z", row16("__LL_", 5), row16("Z_____", 5), 2'd1, 1, 2, 1'b0, 0);
        guess("Q", '0, '0, 1'b1);
        cycle("miss_Q", row16("__LL_", 5), row16("QZ____", 5), 2'd1, 2, 2, 1'b0, 0);
        guess("Z", '0, '0, 1'b1);
        cycle("dup_Z", row16("__LL_", 5), row16("QZ____", 5), 2'd1, 2, 2, 1'b1, 0);
        guess("H", 5'b10000, '0, 1'b0);
        cycle("hit_H", row16("H_LL_", 5), row16("QZ____", 5), 2'd1, 2, 3, 1'b0, 0);
        guess("E", 5'b01000, '0, 1'b0);
        cycle("hit_E", row16("HELL_", 5), row16("QZ____", 5), 2'd1, 2, 4, 1'b0, 0);
        guess("O", 5'b00001, '0, 1'b0);
        cycle("win", row16("Win", 6), hello, 2'd2, 2, 5, 1'b0, 0);
        guess("X", '0, '0, 1'b1);
        cycle("win_hold", row16("Win", 6), hello, 2'd2, 2, 5, 1'b0, 0);

        start = 1'b1;
        cycle("restart", u5, h6, 2'd1, 0, 0, 1'b0, 0);
        guess("A", '0, '0, 1'b1);
        cycle("miss_A", u5, row16("A_____", 5), 2'd1, 1, 0, 1'b0, 0);
        guess("B", '0, '0, 1'b1);
        cycle("miss_B", u5, row16("BA____", 5), 2'd1, 2, 0, 1'b0, 0);
        guess("C", '0, '0, 1'b1);
        cycle("miss_C", u5, row16("CBA___", 5), 2'd1, 3, 0, 1'b0, 0);
        guess("D", '0, '0, 1'b1);
        cycle("miss_D", u5, row16("DCBA__", 5), 2'd1, 4, 0, 1'b0, 0);
        guess("F", '0, '0, 1'b1);
        cycle("miss_F", u5, row16("FDCBA_", 5), 2'd1, 5, 0, 1'b0, 0);
        guess("G", '0, '0, 1'b1);
        cycle("lose", row16("Lose", 6), hello, 2'd3, 6, 0, 1'b0, 0);
        guess("H", 5'b10000, '0, 1'b0);
        cycle("lose_hold", row16("Lose", 6), hello, 2'd3, 6, 0, 1'b0, 0);

        word5 = "WORLD"; start = 1'b1;
        cycle("start_world", u5, h6, 2'd1, 0, 0, 1'b0, 0);
        guess("W", 5'b10000, '0, 1'b0);
        cycle("hit_W", row16("W____", 5), h6, 2'd1, 0, 1, 1'b0, 0);
        rst = 1'b1;
        cycle("mid_rst", bl, bl, 2'd0, 0, 0, 1'b0, 0);
        guess("O", 5'b01000, '0, 1'b0);
        cycle("idle_guess", bl, bl, 2'd0, 0, 0, 1'b0, 0);
        start = 1'b1;
        guess("O", 5'b01000, '0, 1'b0);
        cycle("start_and_guess", u5, h6, 2'd1, 0, 0, 1'b0, 0);
        guess("O", 5'b01000, '0, 1'b0);
        cycle("hit_O", row16("_O___", 5), h6, 2'd1, 0, 1, 1'b0, 0);
        guess("K", 5'b00000, '0, 1'b0);
        cycle("noop", row16("_O___", 5), h6, 2'd1, 0, 1, 1'b0, 0);
        guess("L", 5'b00010, '0, 1'b0);
        cycle("hit_L2", row16("_O_L_", 5), h6, 2'd1, 0, 2, 1'b0, 0);

        rst = 1'b1;
        cycle("w7_reset", bl, bl, 2'd0, 0, 0, 1'b0, 1);
        start = 1'b1;
        cycle("w7_start", row16("_______", 4), h6, 2'd1, 0, 0, 1'b0, 1);
        guess("L", '0, 7'b0011000, 1'b0);
        cycle("w7_hit_L", row16("__LL___", 4), h6, 2'd1, 0, 2, 1'b0, 1);
        guess("W", '0, 7'b0000010, 1'b0);
        cycle("w7_hit_W", row16("__LL_W_", 4), h6, 2'd1, 0, 3, 1'b0, 1);
        guess("Z", '0, '0, 1'b1);
        cycle("w7_miss_Z", row16("__LL_W_", 4), row16("Z_____", 5), 2'd1, 1, 3, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hangman_host_display_gen.md
Name: hangman_host_display_gen

Overview:
- Parametrised host-side LCD row generator for the wireless hangman game. It sits between the host game logic and the 16x2 LCD driver.
- Tracks round state internally: revealed word slots, wrong-guess history, mistake/correct counts and win/lose.
- Drives two space-padded, centred ASCII rows.
- Generalises the fixed 5-letter / 6-mistake host display to configurable word length, mistake limit and row width. Adds duplicate-guess rejection and an explicit round state machine.

Parameters:
- WORD_LEN, 5, letters per secret word (1..ROW_CHARS).
- MAX_MISTAKES, 6, wrong guesses that end the round (1..9, <= ROW_CHARS).
- ROW_CHARS, 16, characters per LCD row.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse: latch word, begin a new round (valid in any state).
- word  input  8*WORD_LEN  secret word, ASCII, char0 in MSBs; sampled only on start.
- guess_valid  input  1  pulse: one guess presented this cycle.
- letter  input  8  guessed ASCII letter.
- index_correct  input  WORD_LEN  per-slot match mask, bit WORD_LEN-1 = char0.
- mistake  input  1  guess is wrong.
- top  output  8*ROW_CHARS  row 1 ASCII, char0 in MSBs.
- bottom  output  8*ROW_CHARS  row 2 ASCII.
- game_state  output  2  IDLE=0, PLAY=1, WIN=2, LOSE=3.
- mistake_cnt  output  4  wrong guesses this round.
- correct_cnt  output  $clog2(WORD_LEN+1)  slots revealed.
- dup_guess  output  1  one-cycle pulse when a repeated letter is rejected.

Behaviour:
- All registers and outputs are updated on posedge clk. rst (synchronous) overrides everything.
- Reset state:
  - state=IDLE; counts=0; dup_guess=0.
  - Word slots = '_' (0x5F); history = '_'.
  - top and bottom = all 0x20.
- Row formatting:
  - A field of N chars starts at char offset L=(ROW_CHARS-N)/2 (floor).
  - All other chars are 0x20. Char0 occupies bits [8*ROW_CHARS-1 -: 8].
- Latency: rows, counts and state reflect an accepted event one cycle after it (registered outputs).
- start (any state, priority over guess_valid):
  - Latch word; clear slots and history to '_'; clear counts; state->PLAY.
  - Next cycle: top = slots, bottom = history.
- guess_valid in IDLE, WIN or LOSE: ignored.
- guess_valid in PLAY, evaluated in this order:
  - Duplicate: letter equals any non-'_' revealed slot or any history entry. Result: dup_guess=1 for one cycle, no other change.
  - mistake=1: wrong guess. index_correct is ignored.
    - Shift history right by one char; letter enters position 0 (newest leftmost). Oldest entry drops.
    - mistake_cnt+1.
    - If the new count == MAX_MISTAKES: state->LOSE.
  - mistake=0 and index_correct!=0: correct guess.
    - Each set bit whose slot is '_' is written with letter.
    - correct_cnt += number of newly written slots. Already-revealed slots are not recounted.
    - If correct_cnt reaches WORD_LEN: state->WIN.
  - mistake=0 and index_correct==0: no-op. dup_guess stays 0.
- Rows by state:
  - IDLE: both rows blank (0x20).
  - PLAY: top = slots field (N=WORD_LEN); bottom = history field (N=MAX_MISTAKES).
  - WIN: top = "Win" (57 69 6E) centred; bottom = latched word centred.
  - LOSE: top = "Lose" (4C 6F 73 65) centred; bottom = latched word centred.
- WIN and LOSE hold until start or rst.
- Counts are held in WIN/LOSE and cleared only on start or rst.
- Simultaneous start and guess_valid: start wins; the guess is dropped.
- rst asserted mid-round returns to IDLE with blank rows on the next edge.
- Elaboration checks:
  - WORD_LEN <= ROW_CHARS.
  - MAX_MISTAKES <= ROW_CHARS and MAX_MISTAKES <= 9.
  - Illegal values are fatal.

Decomposition:
- Package hangman_pkg holds:
  - game_state_t enum.
  - ASCII constants: BLANK 0x20, UNDERSCORE 0x5F, WIN_STR, LOSE_STR.
  - centre_field function: field and N in, row out.
- One sub-module: hangman_guess_history. It is the MAX_MISTAKES-deep shift register with a parallel letter-match output used for duplicate detection.

Test Plan:
- Reset then start with word "HELLO" (48 45 4C 4C 4F), defaults. Expected:
  - top chars5..9 = "_____", rest 0x20.
  - bottom chars5..10 = "______".
  - game_state=PLAY.
- Guess 'L' (0x4C), mistake=0, index_correct=00110. Expected:
  - top chars5..9 = "__LL_"; correct_cnt=2.
  - Then 'L' again: dup_guess=1 for one cycle, no change.
- Guesses 'Z', then 'Q', each mistake=1. Expected:
  - bottom chars5..10 = "QZ____".
  - mistake_cnt=2.
  - Then 'Z' again: dup_guess=1, mistake_cnt stays 2.
- Guesses 'H' 10000, 'E' 01000, 'O' 00001. Expected:
  - Final cycle: state=WIN.
  - top chars6..8 = "Win"; bottom chars5..9 = "HELLO".
  - A further guess_valid is ignored.
- Six distinct wrong guesses A,B,C,D,F,G. Expected:
  - On the 6th: state=LOSE, top chars6..9 = "Lose", bottom = "HELLO".
  - Then start with "WORLD": PLAY, counts 0, slots "_____".
- Mid-round rst, and start coincident with guess_valid. Expected:
  - rst: IDLE, all 0x20, counts 0.
  - start+guess: the guess is not applied.
  - Repeat with WORD_LEN=7, ROW_CHARS=16: slots field at chars 4..10.
